pad_bank_ctrl: RTL



---
 rtl/pad_ctrl_pkg.sv | 19 +
 rtl/pad_in_filter.sv | 51 +++++
 rtl/pad_bank_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/pad_ctrl_pkg.sv
// Shared types and default sizing for the pad bank controller and its input filter.
package pad_ctrl_pkg;

    typedef enum logic [1:0] {
        PadIdle  = 2'd0,
        PadDrive = 2'd1,
        PadTurn  = 2'd2
    } pad_state_e;

    typedef enum logic {
        OwnGpio = 1'b0,
        OwnAlt  = 1'b1
    } pad_owner_e;

    localparam int unsigned DefNumPads    = 8;
    localparam int unsigned DefTurnCycles = 2;
    localparam int unsigned DefFiltW      = 4;

endpackage

// File: rtl/pad_in_filter.sv
// Single-bit 2-flop synchroniser followed by a stable-count glitch filter.
module pad_in_filter #(
    parameter int unsigned FiltW = pad_ctrl_pkg::DefFiltW
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             pad_i,
    input  logic [FiltW-1:0] thr_i,
    output logic             filt_o
);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             filt_q, filt_d;
    logic [FiltW-1:0] cnt_q, cnt_d;
    logic [FiltW:0]   cnt_inc;

    always_comb begin
        sync1_d = pad_i;
        sync2_d = sync1_q;
        filt_d  = filt_q;
        cnt_d   = cnt_q;
        cnt_inc = {1'b0, cnt_q} + {{FiltW{1'b0}}, 1'b1};
        // The counter only runs while a candidate value differs from the output.
        if (sync2_q == filt_q) begin
            cnt_d = '0;
        end else if (cnt_inc >= {1'b0, thr_i}) begin
            filt_d = sync2_q;
            cnt_d  = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_inc[FiltW-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            filt_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/pad_bank_ctrl.sv
// Per-pad owner arbitration with tri-state turnaround, registered pad controls
// and filtered input return for a bank of bidirectional pads.
module pad_bank_ctrl
    import pad_ctrl_pkg::*;
#(
    parameter int unsigned NumPads    = DefNumPads,
    parameter int unsigned TurnCycles = DefTurnCycles,
    parameter int unsigned FiltW      = DefFiltW
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NumPads-1:0] sel_alt_i,
    input  logic [NumPads-1:0] gpio_oe_i,
    input  logic [NumPads-1:0] gpio_out_i,
    input  logic [NumPads-1:0] alt_oe_i,
    input  logic [NumPads-1:0] alt_out_i,
    input  logic [NumPads-1:0] pull_en_i,
    input  logic [FiltW-1:0]   filt_thr_i,
    output logic [NumPads-1:0] pad_oe_o,
    output logic [NumPads-1:0] pad_out_o,
    output logic [NumPads-1:0] pad_pen_o,
    input  logic [NumPads-1:0] pad_in_i,
    output logic [NumPads-1:0] gpio_in_o,
    output logic [NumPads-1:0] alt_in_o,
    output logic [NumPads-1:0] turn_busy_o
);

    localparam int unsigned CntW = (TurnCycles > 1) ? $clog2(TurnCycles) : 1;
    localparam logic [CntW-1:0] TurnLoad = CntW'(TurnCycles - 1);

    logic [NumPads-1:0] pen_q, pen_d;
    logic [NumPads-1:0] filt;

    always_comb begin
        pen_d = pull_en_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pen_q <= '0;
        end else begin
            pen_q <= pen_d;
        end
    end

    assign pad_pen_o = pen_q;
    assign gpio_in_o = filt;

    for (genvar i = 0; i < NumPads; i++) begin : g_pad
        pad_state_e      state_q, state_d;
        pad_owner_e      owner_q, owner_d;
        pad_owner_e      req_owner;
        logic [CntW-1:0] cnt_q, cnt_d;
        logic            out_q, out_d;
        logic            cur_oe, cur_out;

        always_comb begin
            req_owner = sel_alt_i[i] ? OwnAlt : OwnGpio;
            cur_oe    = (owner_q == OwnAlt) ? alt_oe_i[i]  : gpio_oe_i[i];
            cur_out   = (owner_q == OwnAlt) ? alt_out_i[i] : gpio_out_i[i];
            state_d   = state_q;
            owner_d   = owner_q;
            cnt_d     = cnt_q;
            // Any owner change, even back to the previous owner, restarts a full turnaround.
            if (req_owner != owner_q) begin
                state_d = PadTurn;
                owner_d = req_owner;
                cnt_d   = TurnLoad;
            end else begin
                unique case (state_q)
                    PadTurn: begin
                        if (cnt_q == '0) begin
                            state_d = cur_oe ? PadDrive : PadIdle;
                        end else begin
                            cnt_d = cnt_q - CntW'(1);
                        end
                    end
                    PadIdle: begin
                        if (cur_oe) state_d = PadDrive;
                    end
                    PadDrive: begin
                        if (!cur_oe) state_d = PadIdle;
                    end
                    default: state_d = PadIdle;
                endcase
            end
            // When the next state is PadDrive the owner is unchanged, so cur_out is valid.
            out_d = (state_d == PadDrive) ? cur_out : 1'b0;
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q <= PadIdle;
                owner_q <= OwnGpio;
                cnt_q   <= '0;
                out_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                owner_q <= owner_d;
                cnt_q   <= cnt_d;
                out_q   <= out_d;
            end
        end

        assign pad_oe_o[i]    = (state_q == PadDrive);
        assign pad_out_o[i]   = out_q;
        assign turn_busy_o[i] = (state_q == PadTurn);
        assign alt_in_o[i]    = filt[i] & (owner_q == OwnAlt);

        pad_in_filter #(
            .FiltW (FiltW)
        ) u_filter (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .pad_i  (pad_in_i[i]),
            .thr_i  (filt_thr_i),
            .filt_o (filt[i])
        );
    end

endmodule
